// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
// Purpose: loader FSM state encoding and default memory geometry.
// Ports: none (package).
// Build option: PROGRAM_LOADER_CHECKSUM_EN enables the trailing checksum nibble.
package program_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;
  localparam int MEM_DEPTH  = 1 << ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/program_loader_instr_mem.sv
// rtl/program_loader_instr_mem.sv - instruction memory, 1 sync write / 1 async read
// Purpose: 2**ADDR_W x DATA_W storage; contents survive reset.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe, takes effect at the clk edge
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  combinational read data
module instr_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a nibble-stream program into instruction memory
// Purpose: accepts length, instruction and (optionally) checksum nibbles over a
//   valid/ready handshake, writes them into the CPU's instruction memory and
//   holds the CPU in reset until a complete program is loaded.
// Build option: PROGRAM_LOADER_CHECKSUM_EN adds the checksum nibble, the CSUM and
//   ERR states and the running sum register; without it error is tied low.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   start         pulse that begins a load (from IDLE, RUN or ERR)
//   in_valid/in_ready/in_data  nibble stream handshake
//   fetch_addr    CPU program counter
//   fetch_data    instruction at fetch_addr (combinational)
//   cpu_reset     high unless a loaded program is running
//   busy          load in progress
//   done          program loaded, CPU running
//   error         checksum mismatch on last load
//   words_loaded  instructions written in current/last load
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W:0]   count;
  logic              hs;
  logic              last_word;
  logic              wr_en;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign hs        = in_valid && in_ready;
  assign last_word = (count == {1'b0, len});
  assign wr_en     = hs && (state == DATA);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LEN;
      LEN:  if (hs) state_nx = DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      DATA: if (hs && last_word) state_nx = CSUM;
      CSUM: if (hs) state_nx = (in_data == sum) ? RUN : ERR;
      ERR:  if (start) state_nx = LEN;
`else
      DATA: if (hs && last_word) state_nx = RUN;
`endif
      RUN:  if (start) state_nx = LEN;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and never depend combinationally on in_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      len       <= '0;
      count     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      error     <= 1'b0;
      sum       <= '0;
`endif
    end else begin
      state     <= state_nx;
      in_ready  <= (state_nx == LEN) || (state_nx == DATA) || (state_nx == CSUM);
      busy      <= (state_nx == LEN) || (state_nx == DATA) || (state_nx == CSUM);
      cpu_reset <= (state_nx != RUN);
      done      <= (state_nx == RUN);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      error     <= (state_nx == ERR);
`endif
      if (hs && state == LEN) begin
        len   <= ADDR_W'(in_data);
        count <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum   <= in_data;
`endif
      end
      if (wr_en) begin
        count <= count + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum   <= sum + in_data;
`endif
      end
    end
  end

`ifndef PROGRAM_LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

  assign words_loaded = count;

  // count never exceeds len while in DATA, so the low bits are a safe address.
  instr_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_instr_mem (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(count[ADDR_W-1:0]),
    .wr_data(in_data),
    .rd_addr(fetch_addr),
    .rd_data(fetch_data)
  );

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - self-checking bench for program_loader
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic [3:0] fetch_addr = 4'h0;
  logic [3:0] fetch_data;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [3:0] model_mem [16];
  bit         known [16];
  logic [3:0] prog [16];

  program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One nibble; optional idle gaps carry junk data and stray start pulses.
  task automatic send(input logic [3:0] d, input bit gaps);
    int n;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        start    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 16; a++) begin
      if (known[a]) begin
        @(negedge clk);
        fetch_addr = 4'(a);
        #1;
        check({tag, "_mem"}, 32'(fetch_data), 32'(model_mem[a]));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic load(input int len, input bit bad, input bit gaps, input string tag);
    logic [3:0] sum;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    sum = 4'(len);
    send(4'(len), gaps);
    for (int i = 0; i <= len; i++) begin
      send(prog[i], gaps);
      sum = sum + prog[i];
      model_mem[i] = prog[i];
      known[i] = 1'b1;
    end
    if (CSUM_EN) send(bad ? sum + 4'd1 : sum, gaps);
    check({tag, "_done"}, 32'(done), 32'(!(CSUM_EN && bad)));
    check({tag, "_error"}, 32'(error), 32'(CSUM_EN && bad));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(CSUM_EN && bad));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(len + 1));
    check_mem(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(in_ready), 32'd0);

    prog[0] = 4'h2; prog[1] = 4'h3; prog[2] = 4'hE;
    load(2, 1'b0, 1'b0, "good");
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    load(2, 1'b1, 1'b0, "bad");
    load(2, 1'b0, 1'b0, "recover");
`endif

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) prog[i] = 4'($urandom);
      load($urandom_range(0, 15), 1'b0, 1'b1, "rand");
    end

    for (int i = 0; i < 16; i++) prog[i] = 4'($urandom);
    load(5, 1'b0, 1'b0, "b2b");
    load(5, 1'b0, 1'b1, "gaps");

    for (int i = 0; i < 16; i++) prog[i] = 4'(i);
    load(15, 1'b0, 1'b0, "full");

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rerun_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rerun_done", 32'(done), 32'd0);
    check("rerun_busy", 32'(busy), 32'd1);

    send(4'h3, 1'b0);
    send(4'hA, 1'b0);
    send(4'h5, 1'b0);
    model_mem[0] = 4'hA;
    model_mem[1] = 4'h5;
    check("mid_words", 32'(words_loaded), 32'd2);
    reset = 1'b1;
    #1;
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_mem("mid_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
